timer_sched: RTL and testbench

Multi-channel timer scheduler and interrupt controller for the PicoRV32 SoC peripheral bus. Each channel owns a programmable reload value, a down-counter driven by a shared prescaler, one-shot or periodic mode, and a sticky pending flag that raises an interrupt. The block sits beside the free-running timers on the same native memory bus, decoded by the SoC address decoder through `enable`. Its `irq` outputs feed the CPU interrupt inputs.

---
 rtl/timer_sched.sv | 133 +++++++++++++
 tb/tb_timer_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// Multi-channel prescaled down-counter scheduler with sticky pending flags and IRQ outputs.
// Bus: one-cycle registered mem_ready per access, no re-accept while mem_valid is held; irq is combinational.
module timer_sched #(
  parameter int NCH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_instr,
  input  logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_addr,
  output logic [31:0]     mem_rdata,
  output logic            irq,
  output logic [NCH-1:0]  irq_vec
);

  logic [NCH-1:0] ch_en, ch_per, ch_ie, ch_pend;
  logic [31:0]    ch_load  [NCH];
  logic [31:0]    ch_count [NCH];
  logic [15:0]    prescale, pc;
  logic           done;

  logic           acc, wr, tick, sel_glb;
  logic [1:0]     reg_sel;
  logic [NCH-1:0] sel, wr_ctrl, wr_load, wr_stat, start, ev, dec;
  logic           unused_bits;

  assign unused_bits = ^{mem_instr, mem_addr[31:7], mem_addr[1:0]};

  // done holds off a second accept until the master drops mem_valid
  assign acc     = mem_valid & enable & ~mem_ready & ~done;
  assign wr      = acc & (|mem_wstrb);
  assign tick    = (pc == prescale);
  assign reg_sel = mem_addr[3:2];
  assign sel_glb = (mem_addr[6:2] == 5'b10000);

  always_comb begin
    sel     = '0;
    wr_ctrl = '0;
    wr_load = '0;
    wr_stat = '0;
    start   = '0;
    ev      = '0;
    dec     = '0;
    for (int n = 0; n < NCH; n++) begin
      sel[n]     = ~mem_addr[6] & (mem_addr[5:4] == 2'(n));
      wr_ctrl[n] = wr & sel[n] & (reg_sel == 2'd0);
      wr_load[n] = wr & sel[n] & (reg_sel == 2'd1);
      wr_stat[n] = wr & sel[n] & (reg_sel == 2'd3);
      start[n]   = wr_ctrl[n] & mem_wdata[0] & ~ch_en[n];
      ev[n]      = tick & ch_en[n] & (ch_count[n] == 32'd1);
      dec[n]     = tick & ch_en[n] & (ch_count[n] > 32'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      done      <= 1'b0;
      prescale  <= '0;
      pc        <= '0;
      ch_en     <= '0;
      ch_per    <= '0;
      ch_ie     <= '0;
      ch_pend   <= '0;
      for (int n = 0; n < NCH; n++) begin
        ch_load[n]  <= '0;
        ch_count[n] <= '0;
      end
    end else begin
      mem_ready <= acc;
      done      <= mem_valid & (done | mem_ready);

      if (wr && sel_glb) begin
        prescale <= mem_wdata[15:0];
        pc       <= '0;
      end else begin
        pc <= tick ? 16'd0 : pc + 16'd1;
      end

      for (int n = 0; n < NCH; n++) begin
        // A CTRL write wins the register; the tick in the same cycle still sees the old EN/PERIODIC
        if (wr_ctrl[n]) begin
          ch_en[n]  <= mem_wdata[0];
          ch_per[n] <= mem_wdata[1];
          ch_ie[n]  <= mem_wdata[2];
        end else if (ev[n] && !ch_per[n]) begin
          ch_en[n] <= 1'b0;
        end

        if (wr_load[n])
          ch_load[n] <= mem_wdata;

        if (start[n])
          ch_count[n] <= ch_load[n];
        else if (ev[n])
          ch_count[n] <= ch_per[n] ? ch_load[n] : 32'd0;
        else if (dec[n])
          ch_count[n] <= ch_count[n] - 32'd1;

        if (ev[n])
          ch_pend[n] <= 1'b1;
        else if (wr_stat[n] && mem_wdata[0])
          ch_pend[n] <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (enable) begin
      if (sel_glb)
        mem_rdata = {16'd0, prescale};
      for (int n = 0; n < NCH; n++) begin
        if (sel[n]) begin
          case (reg_sel)
            2'd0:    mem_rdata = {29'd0, ch_ie[n], ch_per[n], ch_en[n]};
            2'd1:    mem_rdata = ch_load[n];
            2'd2:    mem_rdata = ch_count[n];
            default: mem_rdata = {31'd0, ch_pend[n]};
          endcase
        end
      end
    end
  end

  assign irq_vec = ch_pend & ch_ie;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: reads are scored by a monitor against a queue of expected data.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_rdata;
  logic        irq;
  logic [1:0]  irq_vec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  timer_sched #(.NCH(2)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every read acknowledge pops one expected value
  always @(negedge clk) begin
    if (resetn && mem_ready && mem_wstrb == 4'd0) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL rd_unexpected: addr 0x%0h data 0x%0h with no expectation", mem_addr, mem_rdata);
      end else begin
        check($sformatf("rd@%0h", addr_q.pop_front()), mem_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1; mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(negedge clk); #1;
    end else begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL bus_timeout: addr 0x%0h got no mem_ready, required one", a);
    end
    mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(a, 4'hf, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    addr_q.push_back(a);
    bus(a, 4'h0, 32'd0);
  endtask

  task automatic wait_irq(input int ch, output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (irq_vec[ch]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL irq_timeout: channel %0d never raised irq_vec, required within 200 clocks", ch);
    end
  endtask

  initial begin
    int tc, t1, t2, t3, pulses;

    // Reset state
    #2;
    check("rst0_ready", {31'd0, mem_ready}, 32'd0);
    check("rst0_irq", {31'd0, irq}, 32'd0);
    check("rst0_irq_vec", {30'd0, irq_vec}, 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    rd(32'h40, 32'h0);
    rd(32'h00, 32'h0);

    // One-shot, PRESCALE=0: event 5 clocks after the CTRL commit
    wr(32'h40, 32'h0);
    wr(32'h04, 32'd5);
    wr(32'h00, 32'h5);
    repeat (4) @(negedge clk);
    check("oneshot_irq_early", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    check("oneshot_irq_vec", {30'd0, irq_vec}, 32'h1);
    rd(32'h08, 32'd0);
    rd(32'h00, 32'h4);
    rd(32'h0C, 32'h1);
    repeat (20) @(negedge clk);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h0);
    repeat (30) @(negedge clk);
    check("oneshot_no_repeat", {31'd0, irq}, 32'd0);

    // Conflict: W1C lands on the same edge as the channel-0 event
    wr(32'h04, 32'd2);
    wr(32'h00, 32'h5);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h1);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h0);

    // LOAD=0 with EN=1 stays idle
    wr(32'h04, 32'd0);
    wr(32'h00, 32'h5);
    repeat (100) @(negedge clk);
    check("load0_irq", {31'd0, irq}, 32'd0);
    rd(32'h0C, 32'h0);
    rd(32'h00, 32'h5);
    wr(32'h00, 32'h0);

    // Periodic LOAD=4, LOAD changed to 10 mid-count
    wr(32'h04, 32'd4);
    wr(32'h00, 32'h7);
    tc = cyc;
    wr(32'h04, 32'd10);
    wait_irq(0, t1);
    check("midload_first", t1 - tc, 32'd4);
    wr(32'h0C, 32'h1);
    wait_irq(0, t2);
    check("midload_second", t2 - t1, 32'd10);
    wr(32'h0C, 32'h1);
    wait_irq(0, t3);
    check("midload_third", t3 - t2, 32'd10);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h0);

    // COUNT readback while running and frozen (stop write coincides with a tick)
    wr(32'h04, 32'd1000);
    wr(32'h00, 32'h1);
    rd(32'h08, 32'd998);
    wr(32'h00, 32'h0);
    rd(32'h08, 32'd996);
    wr(32'h08, 32'd123);
    rd(32'h08, 32'd996);

    // Held mem_valid: single acknowledge
    @(posedge clk); #1;
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h14; mem_wstrb = 4'hf; mem_wdata = 32'hA5;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) pulses = pulses + 1;
    end
    #1 mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'd0;
    check("hold_pulses", pulses, 32'd1);
    rd(32'h14, 32'hA5);
    rd(32'h50, 32'h0);
    wr(32'h20, 32'h7);
    rd(32'h20, 32'h0);
    wr(32'h10, 32'hFFFF_FFF8);
    rd(32'h10, 32'h0);

    // Periodic with prescaler: PRESCALE=3, LOAD1=2 -> event every 8 clocks
    wr(32'h40, 32'd3);
    rd(32'h40, 32'd3);
    wr(32'h14, 32'd2);
    wr(32'h10, 32'h7);
    wait_irq(1, t1);
    wr(32'h1C, 32'h1);
    check("per_cleared", {30'd0, irq_vec}, 32'h0);
    wait_irq(1, t2);
    check("per_period", t2 - t1, 32'd8);
    wr(32'h1C, 32'h1);
    wait_irq(1, t3);
    check("per_period2", t3 - t2, 32'd8);
    wr(32'h10, 32'h4);
    rd(32'h1C, 32'h1);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    wr(32'h10, 32'h0);
    check("ie_mask_irq", {31'd0, irq}, 32'd0);
    rd(32'h1C, 32'h1);
    wr(32'h10, 32'h4);

    // Reset while mem_ready is high
    @(posedge clk); #1;
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h40; mem_wstrb = 4'hf; mem_wdata = 32'h55;
    @(posedge clk); #1;
    check("rst_pre_ready", {31'd0, mem_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    mem_wstrb = 4'd0;
    #1;
    check("rst_rd40", mem_rdata, 32'h0);
    mem_addr = 32'h14;
    #1;
    check("rst_rd14", mem_rdata, 32'h0);
    mem_valid = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rd(32'h40, 32'h0);
    rd(32'h10, 32'h0);
    rd(32'h1C, 32'h0);

    repeat (3) @(negedge clk);
    check("rd_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
